// File: rtl/promoter_pkg.sv
// Shared types for the best-track promoter scheduler: candidate record, promotion modes, FSM states.
package promoter_pkg;

  localparam int KEY_W = 7;
  localparam int Q_W   = 2;

  typedef struct packed {
    logic             v;
    logic [Q_W-1:0]   q;
    logic [KEY_W-1:0] key;
  } cand_t;

  typedef enum logic [1:0] {
    PM_COLL = 2'd0,
    PM_ACC  = 2'd1,
    PM_ALT  = 2'd2
  } pmode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } state_t;

endpackage

// File: rtl/best2_merge.sv
// Combinational insertion of one candidate into a running {best1, best2} pair.
// Ghost cancellation (adjacent-key duplicates of best1) is enabled by PROMOTER_CTL_GHOST_EN.
module best2_merge
  import promoter_pkg::*;
(
  input  cand_t cand,
  input  cand_t best1_in,
  input  cand_t best2_in,
  output cand_t best1_out,
  output cand_t best2_out
);

  logic ghost;

`ifdef PROMOTER_CTL_GHOST_EN
  logic [KEY_W-1:0] kdiff;
  assign kdiff = (cand.key >= best1_in.key) ? (cand.key - best1_in.key)
                                            : (best1_in.key - cand.key);
  assign ghost = best1_in.v && (cand.q <= best1_in.q) && (kdiff <= KEY_W'(1));
`else
  assign ghost = 1'b0;
`endif

  // Strict > keeps the earlier (lower-index) segment on equal quality.
  always_comb begin
    best1_out = best1_in;
    best2_out = best2_in;
    if (cand.v && !ghost) begin
      if (!best1_in.v || (cand.q > best1_in.q)) begin
        best2_out = best1_in;
        best1_out = cand;
      end else if (!best2_in.v || (cand.q > best2_in.q)) begin
        best2_out = cand;
      end
    end
  end

endmodule

// File: rtl/promoter_ctl.sv
// Per-BX scheduler: snapshots NSEG segments on bx_strobe, scans one per cycle, emits best-two per class.
// Optional ghost cancellation in the merge is enabled by defining PROMOTER_CTL_GHOST_EN.
module promoter_ctl
  import promoter_pkg::*;
#(
  parameter int NSEG = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bx_strobe,
  input  logic [NSEG*KEY_W-1:0] seg_ckey,
  input  logic [NSEG*Q_W-1:0]   seg_cq,
  input  logic [NSEG-1:0]       seg_cv,
  input  logic [NSEG*KEY_W-1:0] seg_akey,
  input  logic [NSEG*Q_W-1:0]   seg_aq,
  input  logic [NSEG-1:0]       seg_av,
  input  logic [1:0]            cfg_pmode,
  output logic [KEY_W-1:0]      c1_key,
  output logic [Q_W-1:0]        c1_q,
  output logic                  c1_v,
  output logic [KEY_W-1:0]      c2_key,
  output logic [Q_W-1:0]        c2_q,
  output logic                  c2_v,
  output logic [KEY_W-1:0]      a1_key,
  output logic [Q_W-1:0]        a1_q,
  output logic                  a1_v,
  output logic [KEY_W-1:0]      a2_key,
  output logic [Q_W-1:0]        a2_q,
  output logic                  a2_v,
  output logic                  p_out,
  output logic                  out_valid,
  output logic                  busy,
  output logic [7:0]            ovf_cnt
);

  localparam int CNT_W = $clog2(NSEG);

  state_t state, state_nxt;
  logic load_snap, scan, drop, last;

  logic [CNT_W-1:0]      seg_cnt;
  logic [NSEG*KEY_W-1:0] snap_ckey, snap_akey;
  logic [NSEG*Q_W-1:0]   snap_cq, snap_aq;
  logic [NSEG-1:0]       snap_cv, snap_av;

  cand_t c_b1, c_b2, a_b1, a_b2;
  cand_t c_m1, c_m2, a_m1, a_m2;
  cand_t c_cand, a_cand;
  cand_t c1_r, c2_r, a1_r, a2_r;

  logic toggle, p_hold, p_now;

  assign last = (seg_cnt == CNT_W'(NSEG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_snap = 1'b0;
    scan      = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (bx_strobe) begin
          load_snap = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        scan = 1'b1;
        drop = bx_strobe;
        if (last) state_nxt = EMIT;
      end
      EMIT: begin
        if (bx_strobe) begin
          load_snap = 1'b1;
          state_nxt = SCAN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    c_cand.v   = snap_cv[seg_cnt];
    c_cand.q   = snap_cq[seg_cnt*Q_W +: Q_W];
    c_cand.key = snap_ckey[seg_cnt*KEY_W +: KEY_W];
    a_cand.v   = snap_av[seg_cnt];
    a_cand.q   = snap_aq[seg_cnt*Q_W +: Q_W];
    a_cand.key = snap_akey[seg_cnt*KEY_W +: KEY_W];
  end

  best2_merge u_coll_merge (
    .cand(c_cand), .best1_in(c_b1), .best2_in(c_b2), .best1_out(c_m1), .best2_out(c_m2)
  );

  best2_merge u_acc_merge (
    .cand(a_cand), .best1_in(a_b1), .best2_in(a_b2), .best1_out(a_m1), .best2_out(a_m2)
  );

  // Output registers load from the final merge so they are valid in the EMIT cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_cnt   <= '0;
      snap_ckey <= '0;
      snap_cq   <= '0;
      snap_cv   <= '0;
      snap_akey <= '0;
      snap_aq   <= '0;
      snap_av   <= '0;
      c_b1      <= '0;
      c_b2      <= '0;
      a_b1      <= '0;
      a_b2      <= '0;
      c1_r      <= '0;
      c2_r      <= '0;
      a1_r      <= '0;
      a2_r      <= '0;
      ovf_cnt   <= '0;
    end else begin
      if (load_snap) begin
        snap_ckey <= seg_ckey;
        snap_cq   <= seg_cq;
        snap_cv   <= seg_cv;
        snap_akey <= seg_akey;
        snap_aq   <= seg_aq;
        snap_av   <= seg_av;
        c_b1      <= '0;
        c_b2      <= '0;
        a_b1      <= '0;
        a_b2      <= '0;
        seg_cnt   <= '0;
      end else if (scan) begin
        c_b1 <= c_m1;
        c_b2 <= c_m2;
        a_b1 <= a_m1;
        a_b2 <= a_m2;
        if (last) begin
          c1_r <= c_m1;
          c2_r <= c_m2;
          a1_r <= a_m1;
          a2_r <= a_m2;
        end else begin
          seg_cnt <= seg_cnt + 1'b1;
        end
      end
      if (drop && (ovf_cnt != 8'hFF)) ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

  // cfg_pmode is looked at only during EMIT; p_hold keeps the emitted value afterwards.
  always_comb begin
    case (pmode_t'(cfg_pmode))
      PM_ACC:  p_now = 1'b1;
      PM_ALT:  p_now = toggle;
      default: p_now = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle <= 1'b0;
      p_hold <= 1'b0;
    end else if (state == EMIT) begin
      p_hold <= p_now;
      if (pmode_t'(cfg_pmode) == PM_ALT) toggle <= ~toggle;
    end
  end

  assign p_out     = (state == EMIT) ? p_now : p_hold;
  assign out_valid = (state == EMIT);
  assign busy      = (state == SCAN);

  assign c1_key = c1_r.key;
  assign c1_q   = c1_r.q;
  assign c1_v   = c1_r.v;
  assign c2_key = c2_r.key;
  assign c2_q   = c2_r.q;
  assign c2_v   = c2_r.v;
  assign a1_key = a1_r.key;
  assign a1_q   = a1_r.q;
  assign a1_v   = a1_r.v;
  assign a2_key = a2_r.key;
  assign a2_q   = a2_r.q;
  assign a2_v   = a2_r.v;

endmodule
